// File: rtl/niossoc_switch_poller.sv
// Polls the switch PIO over an Avalon-MM master, debounces samples and queues change events for the CPU.
// Optional build macro SWPOLL_TIMESTAMP_EN stamps each event with the poll counter in bits [31:WIDTH].
module niossoc_switch_poller #(
   parameter int WIDTH          = 18,
   parameter int POLL_DIV       = 50000,
   parameter int STABLE_SAMPLES = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int READ_LATENCY   = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic [1:0]       m_address,
   output logic             m_read,
   input  logic [31:0]      m_readdata,
   input  logic [1:0]       s_address,
   input  logic             s_read,
   input  logic             s_write,
   input  logic [31:0]      s_writedata,
   output logic [31:0]      s_readdata,
   output logic             irq,
   output logic [WIDTH-1:0] sw_state
);
   localparam int TMR_W  = $clog2(POLL_DIV);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int STAB_W = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
   localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_SAMPLES - 1);

   typedef enum logic [1:0] {IDLE, READ, WAIT, CAPTURE} state_t;
   state_t state_reg, state_next;

   logic              enable_reg, irq_en_reg, overflow_reg;
   logic [TMR_W-1:0]  timer_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic [WIDTH-1:0]  candidate_reg, candidate_next, sample;
   logic [STAB_W-1:0] stab_reg, stab_next;
   logic              tick, capture, accept;
   logic [31:0]       event_word, status_word, reg_q;
   logic [31:0]       mem [FIFO_DEPTH];
   logic [31:0]       mem_q;
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [LVL_W-1:0]  level_reg;
   logic              full, empty, pop, do_push, ovf_set, data_sel_reg;
   logic              unused_bits;

   assign unused_bits = ^{s_writedata, m_readdata};
   assign m_address   = 2'd0;
   assign tick        = enable_reg && (timer_reg == TMR_W'(POLL_DIV - 1));
   assign capture     = (state_reg == CAPTURE);
   assign sample      = m_readdata[WIDTH-1:0];
   assign full        = (level_reg == LVL_W'(FIFO_DEPTH));
   assign empty       = (level_reg == '0);
   assign pop         = s_read && (s_address == 2'd0) && !empty;
   assign do_push     = accept && (!full || pop);
   assign ovf_set     = accept && full && !pop;
   assign irq         = irq_en_reg && !empty;
   assign s_readdata  = data_sel_reg ? mem_q : reg_q;

   always_comb begin
      state_next = state_reg;
      m_read     = 1'b0;
      case (state_reg)
         IDLE:    if (tick) state_next = READ;
         READ: begin
            m_read     = 1'b1;
            state_next = (READ_LATENCY > 1) ? WAIT : CAPTURE;
         end
         WAIT:    if (wait_cnt_reg == WAIT_W'(READ_LATENCY - 2)) state_next = CAPTURE;
         CAPTURE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A sample differing from the candidate restarts the stability count.
   always_comb begin
      candidate_next = candidate_reg;
      stab_next      = stab_reg;
      if (sample != candidate_reg) begin
         candidate_next = sample;
         stab_next      = '0;
      end else if (stab_reg != STAB_MAX) begin
         stab_next = stab_reg + STAB_W'(1);
      end
   end
   assign accept = capture && (stab_next == STAB_MAX) && (candidate_next != sw_state);

`ifdef SWPOLL_TIMESTAMP_EN
   logic [31:0] poll_cnt_reg;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     poll_cnt_reg <= '0;
      else if (capture) poll_cnt_reg <= poll_cnt_reg + 32'd1;
   end
`endif

   always_comb begin
      event_word             = '0;
      event_word[WIDTH-1:0]  = candidate_next;
`ifdef SWPOLL_TIMESTAMP_EN
      event_word[31:WIDTH]   = poll_cnt_reg[31-WIDTH:0];
`endif
   end

   always_comb begin
      status_word            = '0;
      status_word[LVL_W-1:0] = level_reg;
      status_word[16]        = empty;
      status_word[17]        = full;
      status_word[18]        = overflow_reg;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         timer_reg     <= '0;
         wait_cnt_reg  <= '0;
         enable_reg    <= 1'b0;
         irq_en_reg    <= 1'b0;
         overflow_reg  <= 1'b0;
         candidate_reg <= '0;
         stab_reg      <= '0;
         sw_state      <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         reg_q         <= '0;
         data_sel_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (!enable_reg || tick) timer_reg <= '0;
         else                     timer_reg <= timer_reg + TMR_W'(1);
         if (state_reg == READ)      wait_cnt_reg <= '0;
         else if (state_reg == WAIT) wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
         if (capture) begin
            candidate_reg <= candidate_next;
            stab_reg      <= stab_next;
         end
         if (accept) sw_state <= candidate_next;
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (do_push && !pop)      level_reg <= level_reg + LVL_W'(1);
         else if (pop && !do_push) level_reg <= level_reg - LVL_W'(1);
         // A new overflow wins over a same-cycle clear.
         if (ovf_set)
            overflow_reg <= 1'b1;
         else if (s_write && s_address == 2'd1 && s_writedata[18])
            overflow_reg <= 1'b0;
         if (s_write && s_address == 2'd2) begin
            enable_reg <= s_writedata[0];
            irq_en_reg <= s_writedata[1];
         end
         data_sel_reg <= pop;
         reg_q        <= '0;
         if (s_read) begin
            case (s_address)
               2'd1:    reg_q <= status_word;
               2'd2:    reg_q <= {30'd0, irq_en_reg, enable_reg};
               2'd3:    reg_q <= {{(32-WIDTH){1'b0}}, sw_state};
               default: reg_q <= '0;
            endcase
         end
      end
   end

   // Event storage without reset so it maps onto block RAM with a registered read port.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= event_word;
      if (pop)     mem_q <= mem[rd_ptr_reg];
   end
endmodule

// File: tb/tb_niossoc_switch_poller.sv
// Directed bench for niossoc_switch_poller: slave reads push expectations, a monitor pops and compares.
module tb_niossoc_switch_poller;
   localparam int W = 18;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    m_address;
   logic          m_read;
   logic [31:0]   m_readdata;
   logic [1:0]    s_address = 2'd0;
   logic          s_read = 1'b0;
   logic          s_write = 1'b0;
   logic [31:0]   s_writedata = 32'd0;
   logic [31:0]   s_readdata;
   logic          irq;
   logic [W-1:0]  sw_state;
   logic [W-1:0]  pio = '0;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   logic [31:0]   exp_q[$];
   string         name_q[$];

   niossoc_switch_poller #(
      .WIDTH(W), .POLL_DIV(8), .STABLE_SAMPLES(3), .FIFO_DEPTH(4), .READ_LATENCY(1)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
      .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
      .s_readdata(s_readdata), .irq(irq), .sw_state(sw_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Switch PIO: registered readdata, upper bits carry junk the poller must ignore.
   always @(posedge clk or negedge reset_n)
      if (!reset_n)    m_readdata <= 32'd0;
      else if (m_read) m_readdata <= {14'h3A5A, pio};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end else
         $display("ok   %s: 0x%08h", nm, act);
   endtask

   initial begin : monitor
      logic rd;
      forever begin
         @(posedge clk);
         rd = s_read;
         #1;
         if (rd) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_read: got 0x%08h with no expectation", s_readdata);
            end else
               check(name_q.pop_front(), s_readdata, exp_q.pop_front());
         end
      end
   end

   task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
      @(negedge clk);
      exp_q.push_back(e);
      name_q.push_back(nm);
      s_address = a;
      s_read    = 1'b1;
      @(negedge clk);
      s_read    = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      s_address   = a;
      s_writedata = d;
      s_write     = 1'b1;
      @(negedge clk);
      s_write     = 1'b0;
      $display("wr   addr %0d <= 0x%08h", a, d);
   endtask

   task automatic wait_mread();
      bit got = 1'b0;
      repeat (40) if (!got) begin
         @(negedge clk);
         got = m_read;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL poll_timeout: got no m_read within 40 cycles, required a poll");
      end
   endtask

   // Returns two cycles after the last poll's READ, i.e. after its capture has landed.
   task automatic wait_polls(input int n);
      repeat (n) wait_mread();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int t0, t1, seen;
      repeat (3) @(negedge clk);
      check("reset_s_readdata", s_readdata, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      check("reset_sw_state", {14'd0, sw_state}, 32'd0);
      check("reset_m_read", {31'd0, m_read}, 32'd0);
      reset_n = 1'b1;
      rd(2'd1, 32'h0001_0000, "status_reset");
      rd(2'd2, 32'd0, "ctrl_reset");

      wr(2'd2, 32'd1);
      rd(2'd2, 32'd1, "ctrl_enable");
      wait_mread();
      t0 = cyc;
      check("m_address", {30'd0, m_address}, 32'd0);
      @(negedge clk);
      check("m_read_one_cycle", {31'd0, m_read}, 32'd0);
      wait_mread();
      t1 = cyc;
      check("poll_period", t1 - t0, 32'd8);
      wait_polls(1);
      check("sw_state_idle", {14'd0, sw_state}, 32'd0);
      check("irq_idle", {31'd0, irq}, 32'd0);
      rd(2'd1, 32'h0001_0000, "status_no_event");

      wait_polls(1);
      pio = 18'h00005;
      wait_polls(2);
      check("sw_state_after_2_polls", {14'd0, sw_state}, 32'd0);
      wait_polls(1);
      check("sw_state_after_3_polls", {14'd0, sw_state}, 32'h5);
      check("irq_disabled", {31'd0, irq}, 32'd0);
      rd(2'd1, 32'h0000_0001, "status_one_event");
      rd(2'd0, 32'h0000_0005, "data_first_event");
      rd(2'd1, 32'h0001_0000, "status_drained");
      rd(2'd3, 32'h0000_0005, "state_reg");

      wait_polls(1);
      for (int i = 0; i < 6; i++) begin
         pio = (i % 2 == 0) ? 18'h1 : 18'h0;
         wait_polls(1);
      end
      check("sw_state_toggle", {14'd0, sw_state}, 32'h5);
      rd(2'd1, 32'h0001_0000, "status_toggle");

      wait_polls(1);
      for (int i = 1; i <= 6; i++) begin
         pio = W'(i * 16);
         wait_polls(3);
      end
      check("sw_state_after_6", {14'd0, sw_state}, 32'h60);
      rd(2'd1, 32'h0006_0004, "status_overflow");
      wr(2'd1, 32'h0004_0000);
      rd(2'd1, 32'h0002_0004, "status_ovf_cleared");
      for (int i = 1; i <= 4; i++) rd(2'd0, 32'(i * 16), $sformatf("data_drain%0d", i));
      rd(2'd1, 32'h0001_0000, "status_after_drain");

      wr(2'd2, 32'd3);
      check("irq_no_event", {31'd0, irq}, 32'd0);
      wait_polls(1);
      pio = 18'h00077;
      wait_polls(3);
      check("irq_pending", {31'd0, irq}, 32'd1);
      rd(2'd0, 32'h0000_0077, "data_irq_event");
      check("irq_after_pop", {31'd0, irq}, 32'd0);
      rd(2'd0, 32'd0, "data_empty");
      rd(2'd1, 32'h0001_0000, "status_empty");

      wait_polls(1);
      for (int i = 1; i <= 4; i++) begin
         pio = W'(i);
         wait_polls(3);
      end
      rd(2'd1, 32'h0002_0004, "status_full");
      wait_polls(1);
      pio = 18'h00005;
      wait_polls(2);
      wait_mread();
      rd(2'd0, 32'h0000_0001, "data_push_pop");
      rd(2'd1, 32'h0002_0004, "status_push_pop");
      check("sw_state_push_pop", {14'd0, sw_state}, 32'h5);
      for (int i = 2; i <= 5; i++) rd(2'd0, 32'(i), $sformatf("data_tail%0d", i));
      rd(2'd1, 32'h0001_0000, "status_final");

      wait_polls(1);
      wr(2'd2, 32'd0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (m_read) seen++;
      end
      check("no_poll_when_disabled", seen, 32'd0);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pending_reads: got %0d unchecked, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
